// File: rtl/instruction_prefetch.sv
// Instruction prefetch: single-outstanding fetch FSM feeding a small tagged FIFO
// that presents words on the decoder's I / p_cache_miss interface.
module instruction_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          n_RST,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_target,
    output logic          fetch_req,
    output logic [AW-1:0] fetch_addr,
    input  logic          fetch_ack,
    input  logic [15:0]   fetch_data,
    input  logic          hazard,
    output logic [15:0]   I,
    output logic          p_cache_miss,
    output logic [AW-1:0] I_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

    state_t        state_q, state_d;
    logic          fetch_req_q, fetch_req_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          hz_shadow_q;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [15:0]   data_mem [DEPTH];

    logic empty, push, pop;

    assign empty        = (count_q == '0);
    assign p_cache_miss = empty | pc_load;
    assign I            = p_cache_miss ? 16'h0000 : data_mem[rd_ptr_q];
    assign I_addr       = empty ? '0 : addr_mem[rd_ptr_q];
    // hz_shadow=1 means the decoder already holds this word in its alternate register.
    assign pop          = ~p_cache_miss & ~hz_shadow_q;
    assign push         = (state_q == WAIT) & fetch_ack & ~pc_load;

    assign fetch_req  = fetch_req_q;
    assign fetch_addr = fetch_addr_q;

    always_comb begin
        count_d = count_q;
        if (pc_load) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    fetch_addr_d = pc_target;
                end else if (count_q < FULL_COUNT) begin
                    fetch_req_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (fetch_ack) begin
                    fetch_req_d  = 1'b0;
                    state_d      = IDLE;
                    fetch_addr_d = pc_load ? pc_target : fetch_addr_q + ADDR_ONE;
                end else if (pc_load) begin
                    pend_addr_d = pc_target;
                    state_d     = WAIT_DISCARD;
                end
            end
            WAIT_DISCARD: begin
                // The cache handshake must complete; its data is stale and dropped.
                if (fetch_ack) begin
                    fetch_req_d  = 1'b0;
                    state_d      = IDLE;
                    fetch_addr_d = pc_load ? pc_target : pend_addr_q;
                end else if (pc_load) begin
                    pend_addr_d = pc_target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_RST) begin
            state_q      <= IDLE;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            pend_addr_q  <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hz_shadow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            count_q      <= count_d;
            if (!p_cache_miss) begin
                hz_shadow_q <= hazard;
            end
            if (pc_load) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_RST && push) begin
            addr_mem[wr_ptr_q] <= fetch_addr_q;
            data_mem[wr_ptr_q] <= fetch_data;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: a constant vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_instruction_prefetch;

    localparam int DEPTH = 4;
    localparam int AW    = 13;

    logic          clk = 1'b0;
    logic          n_RST;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ack;
    logic [15:0]   fetch_data;
    logic          hazard;
    logic [15:0]   I;
    logic          p_cache_miss;
    logic [AW-1:0] I_addr;

    instruction_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .n_RST(n_RST), .pc_load(pc_load), .pc_target(pc_target),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .hazard(hazard), .I(I),
        .p_cache_miss(p_cache_miss), .I_addr(I_addr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int dead_seen = 0;

    typedef struct {
        logic          rst_n;
        logic          pl;
        logic [AW-1:0] tgt;
        logic          ack;
        logic [15:0]   dat;
        logic          hz;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_miss;
        logic [15:0]   e_i;
        logic [AW-1:0] e_iaddr;
    } vec_t;

    vec_t tbl [13];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } entry_t;

    // Reference model: FIFO as a queue, fetch engine as a few flags.
    entry_t        m_q [$];
    logic          m_req, m_disc, m_hz;
    logic [AW-1:0] m_addr, m_pend;

    logic          obs_req, obs_miss;
    logic [AW-1:0] obs_addr, obs_iaddr;
    logic [15:0]   obs_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic pl, input logic [AW-1:0] tgt,
                                input logic ack, input logic [15:0] d, input logic hz,
                                input logic er, input logic [AW-1:0] ea, input logic em,
                                input logic [15:0] ei, input logic [AW-1:0] eia);
        vec_t v;
        v.rst_n = r; v.pl = pl; v.tgt = tgt; v.ack = ack; v.dat = d; v.hz = hz;
        v.e_req = er; v.e_addr = ea; v.e_miss = em; v.e_i = ei; v.e_iaddr = eia;
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_req = 1'b0; m_disc = 1'b0; m_hz = 1'b0;
        m_addr = '0; m_pend = '0;
    endtask

    task automatic model_advance(input logic rst_n, input logic pl, input logic [AW-1:0] tgt,
                                 input logic ack, input logic [15:0] dat, input logic hz);
        int   sz;
        logic miss;
        logic do_pop;
        entry_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz     = m_q.size();
        miss   = (sz == 0) || pl;
        do_pop = !miss && !m_hz;
        if (!miss) m_hz = hz;
        if (pl) m_q.delete();
        else if (do_pop) e = m_q.pop_front();
        if (!m_req) begin
            if (pl) m_addr = tgt;
            else if (sz < DEPTH) m_req = 1'b1;
        end else if (!m_disc) begin
            if (ack && !pl) begin
                e.addr = m_addr; e.data = dat;
                m_q.push_back(e);
                m_addr = m_addr + 1'b1;
                m_req  = 1'b0;
            end else if (ack) begin
                m_addr = tgt; m_req = 1'b0;
            end else if (pl) begin
                m_pend = tgt; m_disc = 1'b1;
            end
        end else begin
            if (ack) begin
                m_addr = pl ? tgt : m_pend;
                m_req  = 1'b0; m_disc = 1'b0;
            end else if (pl) begin
                m_pend = tgt;
            end
        end
    endtask

    task automatic drive(input logic rst_n, input logic pl, input logic [AW-1:0] tgt,
                         input logic ack, input logic [15:0] dat, input logic hz);
        @(negedge clk);
        n_RST = rst_n; pc_load = pl; pc_target = tgt;
        fetch_ack = ack; fetch_data = dat; hazard = hz;
        #1;
        obs_req = fetch_req; obs_addr = fetch_addr; obs_miss = p_cache_miss;
        obs_i = I; obs_iaddr = I_addr;
        if (!p_cache_miss && I == 16'hDEAD) dead_seen++;
    endtask

    // One cycle checked against the reference model, which then advances.
    task automatic step(input logic rst_n, input logic pl, input logic [AW-1:0] tgt,
                        input logic ack, input logic [15:0] dat, input logic hz);
        logic          e_miss;
        logic [15:0]   e_i;
        logic [AW-1:0] e_iaddr;
        drive(rst_n, pl, tgt, ack, dat, hz);
        e_miss  = (m_q.size() == 0) || pl;
        e_i     = e_miss ? 16'h0000 : m_q[0].data;
        e_iaddr = (m_q.size() == 0) ? '0 : m_q[0].addr;
        check("fetch_req",    32'(obs_req),   32'(m_req));
        check("fetch_addr",   32'(obs_addr),  32'(m_addr));
        check("p_cache_miss", 32'(obs_miss),  32'(e_miss));
        check("I",            32'(obs_i),     32'(e_i));
        check("I_addr",       32'(obs_iaddr), 32'(e_iaddr));
        model_advance(rst_n, pl, tgt, ack, dat, hz);
    endtask

    task automatic hard_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        model_reset();
    endtask

    function automatic logic [15:0] word_for(input logic [AW-1:0] a);
        return 16'h1000 + {3'b000, a};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic          r, pl, ack, hz;
        logic [AW-1:0] tgt;
        logic [15:0]   dat;

        n_RST = 1'b0; pc_load = 1'b0; pc_target = '0;
        fetch_ack = 1'b0; fetch_data = 16'h0; hazard = 1'b0;
        model_reset();

        tbl[0]  = mk(1'b0, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b0, 13'h0,    1'b1, 16'h0,    13'h0);
        tbl[1]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b0, 13'h0,    1'b1, 16'h0,    13'h0);
        tbl[2]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b1, 13'h0,    1'b1, 16'h0,    13'h0);
        tbl[3]  = mk(1'b1, 1'b0, 13'h0,    1'b1, 16'h1000, 1'b0, 1'b1, 13'h0,    1'b1, 16'h0,    13'h0);
        tbl[4]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b0, 13'h1,    1'b0, 16'h1000, 13'h0);
        tbl[5]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b1, 13'h1,    1'b1, 16'h0,    13'h0);
        tbl[6]  = mk(1'b1, 1'b0, 13'h0,    1'b1, 16'h1001, 1'b0, 1'b1, 13'h1,    1'b1, 16'h0,    13'h0);
        tbl[7]  = mk(1'b1, 1'b1, 13'h1FFF, 1'b0, 16'h0,    1'b0, 1'b0, 13'h2,    1'b1, 16'h0,    13'h1);
        tbl[8]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b0, 13'h1FFF, 1'b1, 16'h0,    13'h0);
        tbl[9]  = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b1, 13'h1FFF, 1'b1, 16'h0,    13'h0);
        tbl[10] = mk(1'b1, 1'b0, 13'h0,    1'b1, 16'h2FFF, 1'b0, 1'b1, 13'h1FFF, 1'b1, 16'h0,    13'h0);
        tbl[11] = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b1, 1'b0, 13'h0,    1'b0, 16'h2FFF, 13'h1FFF);
        tbl[12] = mk(1'b1, 1'b0, 13'h0,    1'b0, 16'h0,    1'b0, 1'b1, 13'h0,    1'b1, 16'h0,    13'h0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst_n, tbl[i].pl, tbl[i].tgt, tbl[i].ack, tbl[i].dat, tbl[i].hz);
            check($sformatf("tbl%0d_req", i),   32'(obs_req),   32'(tbl[i].e_req));
            check($sformatf("tbl%0d_addr", i),  32'(obs_addr),  32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_miss", i),  32'(obs_miss),  32'(tbl[i].e_miss));
            check($sformatf("tbl%0d_I", i),     32'(obs_i),     32'(tbl[i].e_i));
            check($sformatf("tbl%0d_Iaddr", i), 32'(obs_iaddr), 32'(tbl[i].e_iaddr));
            $display("tbl%0d: req=%b addr=%h miss=%b I=%h I_addr=%h", i, obs_req, obs_addr, obs_miss, obs_i, obs_iaddr);
        end

        // Fill with hazard held high, then release hazard while the cache stalls.
        hard_reset();
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, '0, m_req, word_for(m_addr), 1'b1);
        check("fill_req_low", 32'(obs_req), 32'(0));
        check("fill_head_valid", 32'(obs_miss), 32'(0));
        $display("fill: head I=%h I_addr=%h req=%b", obs_i, obs_iaddr, obs_req);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        check("stall_miss", 32'(obs_miss), 32'(1));
        step(1'b1, 1'b0, '0, 1'b1, word_for(m_addr), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        $display("stall: released, I=%h I_addr=%h", obs_i, obs_iaddr);

        // Redirect while waiting; the late response must be discarded.
        hard_reset();
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 13'h0ABC, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 16'hDEAD, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        check("redirect_req", 32'(obs_req), 32'(1));
        check("redirect_addr", 32'(obs_addr), 32'(13'h0ABC));
        check("redirect_empty", 32'(obs_miss), 32'(1));
        check("redirect_no_dead", 32'(dead_seen), 32'(0));
        $display("redirect: next request at %h", obs_addr);

        // Redirect coincident with ack, then address wrap.
        step(1'b1, 1'b1, 13'h1FFF, 1'b1, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        check("coinc_addr", 32'(obs_addr), 32'(13'h1FFF));
        step(1'b1, 1'b0, '0, 1'b1, 16'h1234, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        check("wrap_addr", 32'(obs_addr), 32'(13'h0000));
        check("wrap_I", 32'(obs_i), 32'(16'h1234));
        check("wrap_Iaddr", 32'(obs_iaddr), 32'(13'h1FFF));
        $display("wrap: fetch_addr=%h I=%h I_addr=%h", obs_addr, obs_i, obs_iaddr);

        // Reset during an outstanding request, with the ack arriving in reset.
        hard_reset();
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'h5555, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'h5555, 1'b0);
        check("rst_req", 32'(obs_req), 32'(0));
        check("rst_miss", 32'(obs_miss), 32'(1));
        check("rst_addr", 32'(obs_addr), 32'(0));
        step(1'b1, 1'b0, '0, 1'b1, 16'h5555, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 1'b0);
        check("post_rst_req", 32'(obs_req), 32'(1));
        check("post_rst_addr", 32'(obs_addr), 32'(0));
        $display("reset-in-wait: first request at %h", obs_addr);

        // Randomized traffic against the reference model.
        hard_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 149) != 0);
            pl  = ($urandom_range(0, 19) == 0);
            tgt = AW'($urandom);
            hz  = ($urandom_range(0, 2) == 0);
            ack = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            dat = 16'($urandom);
            step(r, pl, tgt, ack, dat, hz);
        end
        $display("random: done, checks so far=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
- Fetch-side counterpart of the instruction decoder. It requests 16-bit instruction words from the program cache and buffers them in a small tagged FIFO.
- It presents them on the decoder's I / p_cache_miss interface, tracking the decoder's hazard replay rule so that no word is lost or duplicated.
- It sits between the program-counter redirect logic, the program cache and the decode stage.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, 13, instruction address width; matches PC_I_field.

Ports:
- clk  in  1  system clock
- n_RST  in  1  synchronous active-low reset
- pc_load  in  1  redirect: flush and restart fetch at pc_target
- pc_target  in  AW  redirect address
- fetch_req  out  1  cache request, registered
- fetch_addr  out  AW  request address, registered
- fetch_ack  in  1  one-cycle response strobe from the cache
- fetch_data  in  16  instruction word, valid with fetch_ack
- hazard  in  1  decoder stall, same signal the decoder sees
- I  out  16  instruction to the decoder
- p_cache_miss  out  1  high = no valid word this cycle (decoder inserts NOP)
- I_addr  out  AW  address tag of I

Behaviour:
- Reset (n_RST=0 at a clk edge): FIFO empty, count=0, fetch_req=0, fetch_addr=0, state=IDLE, hz_shadow=0. While empty, outputs are I=16'h0000, p_cache_miss=1, I_addr=0. Reset overrides everything, including an outstanding request; a late fetch_ack after reset is ignored because the block is in IDLE.
- Each FIFO entry holds {addr, data}.
- Output (combinational from the head):
  - Non-empty and pc_load=0: I=head.data, I_addr=head.addr, p_cache_miss=0.
  - Otherwise: I=0, p_cache_miss=1, I_addr=head.addr (or 0 when empty).
- hz_shadow mirrors the decoder's prev_hazard register: at each edge, if p_cache_miss=0 then hz_shadow<=hazard; otherwise it holds.
- Pop (consume) occurs at an edge when p_cache_miss=0 and hz_shadow=0.
  - This covers a normal issue (hazard=0) and the first hazard cycle, where the decoder captures the word into its alternate register.
  - No pop occurs while hz_shadow=1.
- Fetch FSM states:
  - IDLE: no request outstanding. If pc_load: fetch_addr<=pc_target, stay in IDLE. Else if count<DEPTH: fetch_req<=1, go to WAIT, with fetch_addr holding the address being requested.
  - WAIT: fetch_req=1; fetch_addr is held stable until ack.
    - On fetch_ack with no pc_load: push {fetch_addr, fetch_data}, fetch_addr<=fetch_addr+1 (wraps mod 2^AW), fetch_req<=0, go to IDLE.
    - On pc_load without ack: save pc_target as pend_addr, go to WAIT_DISCARD.
    - On pc_load and ack in the same cycle: drop the data, fetch_addr<=pc_target, fetch_req<=0, go to IDLE.
  - WAIT_DISCARD: fetch_req=1 and fetch_addr unchanged (the handshake is never abandoned).
    - On a further pc_load: pend_addr<=pc_target.
    - On fetch_ack: drop the data; fetch_addr<=pc_target if pc_load else pend_addr; fetch_req<=0; go to IDLE.
- Only one request is outstanding at any time. fetch_req deasserts for at least one cycle between requests, so back-to-back hits give 1 word per 2 cycles.
- pc_load flush: count<=0 and no pop in that cycle. A simultaneous push is dropped, as above.
- Full/empty: a request is only issued when count<DEPTH. Because count cannot rise while a request is outstanding, a push never overflows. Simultaneous push and pop leave count unchanged.
- Popping when empty cannot happen, since p_cache_miss=1 while empty.

Test Plan:
1. Reset, then hold n_RST=1; the cache acks each request 1 cycle after it is sampled with data 16'h1000+addr; hazard=0. Required: fetch_addr sequence 0,1,2,…; I sequence 1000,1001,… with I_addr matching; no duplicates; p_cache_miss=1 on gap cycles.
2. Stall the cache so no ack arrives for 10 cycles while the FIFO drains. Required: p_cache_miss=1 and I=0; hz_shadow frozen; the word is delivered once when ack returns.
3. Fill the FIFO (DEPTH=4) with hazard held high after one pop. Required: count reaches 4, fetch_req stays 0, and the head does not advance. Then drop hazard: one cycle with no pop (hz_shadow=1), then pops resume in order.
4. Assert pc_load with pc_target=13'h0ABC while in WAIT, and ack 3 cycles later with data 16'hDEAD. Required: DEAD is never presented; the next request has fetch_addr=0ABC; the FIFO is empty after the flush.
5. Assert pc_load and fetch_ack in the same cycle, with pc_target=13'h1FFF. Required: data dropped; next request at 1FFF, followed by 0000 (wrap).
6. Pull n_RST low while in WAIT, and send the ack during reset. Required: all outputs at reset values; after release, the first request is at address 0.
